// File: rtl/tge_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one 10GbE core transmit port.
// Oversize packets are cut at MAX_WORDS and their tail is drained upstream.
module tge_tx_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         in_valid,
    input  logic [N_PORTS-1:0]         in_eof,
    input  logic [64*N_PORTS-1:0]      in_data,
    input  logic [32*N_PORTS-1:0]      in_dest_ip,
    input  logic [16*N_PORTS-1:0]      in_dest_port,
    output logic [N_PORTS-1:0]         in_ready,
    output logic                       tx_valid,
    output logic                       tx_end_of_frame,
    output logic [63:0]                tx_data,
    output logic [31:0]                tx_dest_ip,
    output logic [15:0]                tx_dest_port,
    input  logic                       tx_afull,
    input  logic                       tx_overflow,
    output logic [N_PORTS-1:0]         grant,
    output logic [CNT_W*N_PORTS-1:0]   pkt_count,
    output logic [CNT_W*N_PORTS-1:0]   trunc_count,
    output logic                       overflow_seen
);

    localparam int IW = $clog2(N_PORTS);
    localparam int WW = $clog2(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            txv_q, txv_d;
    logic            txe_q, txe_d;
    logic [63:0]     txd_q, txd_d;
    logic [31:0]     ip_q, ip_d;
    logic [15:0]     pt_q, pt_d;
    logic            ovf_q;
    logic            pkt_inc, trunc_inc;
    logic [CNT_W-1:0] pkt_q   [N_PORTS];
    logic [CNT_W-1:0] trunc_q [N_PORTS];

    logic [IW-1:0]   pick;
    logic            sel_valid, sel_eof;
    logic [63:0]     sel_data;
    logic [31:0]     sel_ip;
    logic [15:0]     sel_pt;
    logic [N_PORTS-1:0] gvec;
    logic            at_max;

    // Later k overwritten by earlier k: the nearest valid port after last wins.
    always_comb begin
        pick = last_q;
        for (int k = N_PORTS; k >= 1; k--) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(last_q) + k) % N_PORTS);
            if (in_valid[cand]) pick = cand;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_eof   = 1'b0;
        sel_data  = '0;
        sel_ip    = '0;
        sel_pt    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_valid = in_valid[i];
                sel_eof   = in_eof[i];
                sel_data  = in_data[64*i +: 64];
                sel_ip    = in_dest_ip[32*i +: 32];
                sel_pt    = in_dest_port[16*i +: 16];
            end
        end
    end

    always_comb begin
        gvec = '0;
        if (state_q != S_IDLE) gvec[gidx_q] = 1'b1;
    end

    assign at_max = (wcnt_q == WW'(MAX_WORDS - 1));

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        wcnt_d    = wcnt_q;
        txv_d     = 1'b0;
        txe_d     = 1'b0;
        txd_d     = txd_q;
        ip_d      = ip_q;
        pt_d      = pt_q;
        pkt_inc   = 1'b0;
        trunc_inc = 1'b0;
        in_ready  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!tx_afull && (|in_valid)) begin
                    gidx_d  = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                in_ready = gvec & {N_PORTS{!tx_afull}};
                if (sel_valid && !tx_afull) begin
                    txv_d  = 1'b1;
                    txd_d  = sel_data;
                    txe_d  = sel_eof | at_max;
                    wcnt_d = wcnt_q + WW'(1);
                    if (wcnt_q == '0) begin
                        ip_d = sel_ip;
                        pt_d = sel_pt;
                    end
                    if (sel_eof) begin
                        pkt_inc = 1'b1;
                        last_d  = gidx_q;
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                    end else if (at_max) begin
                        pkt_inc   = 1'b1;
                        trunc_inc = 1'b1;
                        wcnt_d    = '0;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                in_ready = gvec;
                if (sel_valid && sel_eof) begin
                    last_d  = gidx_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(N_PORTS - 1);
            wcnt_q  <= '0;
            txv_q   <= 1'b0;
            txe_q   <= 1'b0;
            txd_q   <= '0;
            ip_q    <= '0;
            pt_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            txv_q   <= txv_d;
            txe_q   <= txe_d;
            txd_q   <= txd_d;
            ip_q    <= ip_d;
            pt_q    <= pt_d;
            ovf_q   <= ovf_q | tx_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                pkt_q[i]   <= '0;
                trunc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (gidx_q == IW'(i)) begin
                    if (pkt_inc)   pkt_q[i]   <= pkt_q[i] + CNT_W'(1);
                    if (trunc_inc) trunc_q[i] <= trunc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
        assign pkt_count[CNT_W*i +: CNT_W]   = pkt_q[i];
        assign trunc_count[CNT_W*i +: CNT_W] = trunc_q[i];
    end

    assign grant           = gvec;
    assign tx_valid        = txv_q;
    assign tx_end_of_frame = txe_q;
    assign tx_data         = txd_q;
    assign tx_dest_ip      = ip_q;
    assign tx_dest_port    = pt_q;
    assign overflow_seen   = ovf_q;

endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Randomized bench for tge_tx_arbiter: packet queues per port, expected
// service order and output stream derived from the arbitration rules.
module tb_tge_tx_arbiter;

    localparam int N  = 4;
    localparam int MW = 8;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_eof;
    logic [64*N-1:0]  in_data;
    logic [32*N-1:0]  in_dest_ip;
    logic [16*N-1:0]  in_dest_port;
    logic [N-1:0]     in_ready;
    logic             tx_valid;
    logic             tx_end_of_frame;
    logic [63:0]      tx_data;
    logic [31:0]      tx_dest_ip;
    logic [15:0]      tx_dest_port;
    logic             tx_afull;
    logic             tx_overflow;
    logic [N-1:0]     grant;
    logic [CW*N-1:0]  pkt_count;
    logic [CW*N-1:0]  trunc_count;
    logic             overflow_seen;

    always #5 clk = ~clk;

    tge_tx_arbiter #(.N_PORTS(N), .MAX_WORDS(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_eof(in_eof), .in_data(in_data),
        .in_dest_ip(in_dest_ip), .in_dest_port(in_dest_port),
        .in_ready(in_ready),
        .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame),
        .tx_data(tx_data), .tx_dest_ip(tx_dest_ip),
        .tx_dest_port(tx_dest_port),
        .tx_afull(tx_afull), .tx_overflow(tx_overflow),
        .grant(grant), .pkt_count(pkt_count), .trunc_count(trunc_count),
        .overflow_seen(overflow_seen)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int npk [N];
    int plen [N][8];
    int srcp [N];
    int srcw [N];
    int exp_trunc [N];
    int ord [$];
    logic [31:0] cap_ip [N];
    logic [15:0] cap_pt [N];
    logic        ev, eeof;
    logic [63:0] ed;
    logic [31:0] eip;
    logic [15:0] ept;
    int afmode, gaps, cyc, rnd;

    function automatic logic [63:0] wd(int p, int k, int w);
        return {16'(p), 16'(k), 16'(w), 16'(rnd)};
    endfunction

    // Expected service order straight from the round-robin rule.
    task automatic prep();
        int rem [N];
        int last, left;
        ord.delete();
        left = 0;
        for (int p = 0; p < N; p++) begin
            rem[p] = npk[p];
            left += npk[p];
            exp_trunc[p] = 0;
            for (int k = 0; k < npk[p]; k++)
                if (plen[p][k] > MW) exp_trunc[p]++;
        end
        last = N - 1;
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (rem[c] > 0) begin
                    ord.push_back(c);
                    rem[c]--;
                    left--;
                    last = c;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        int gi, p;
        logic drn;
        logic [N-1:0] xf;
        @(negedge clk);
        chk("tx_valid", tx_valid, ev);
        if (ev) begin
            chk("tx_data", tx_data, ed);
            chk("tx_eof", tx_end_of_frame, eeof);
            chk("tx_ip", tx_dest_ip, eip);
            chk("tx_port", tx_dest_port, ept);
        end
        for (int q = 0; q < N; q++) begin
            if (srcp[q] < npk[q]) begin
                in_valid[q] = (srcw[q] == 0) || (gaps == 0) ||
                              ($urandom_range(3) != 0);
                in_eof[q]   = (srcw[q] == plen[q][srcp[q]] - 1);
                in_data[64*q +: 64] = wd(q, srcp[q], srcw[q]);
            end else begin
                in_valid[q] = 1'b0;
                in_eof[q]   = 1'b0;
                in_data[64*q +: 64] = {$urandom, $urandom};
            end
            in_dest_ip[32*q +: 32]   = $urandom;
            in_dest_port[16*q +: 16] = 16'($urandom);
        end
        case (afmode)
            1:       tx_afull = ($urandom_range(3) == 0);
            2:       tx_afull = (cyc >= 4 && cyc < 9);
            default: tx_afull = 1'b0;
        endcase
        cyc++;
        #1;
        chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
        chk("ready_outside_grant", 64'(in_ready & ~grant), 64'd0);
        gi = 0;
        for (int q = 0; q < N; q++) if (grant[q]) gi = q;
        drn = (grant != '0) && (srcp[gi] < npk[gi]) && (srcw[gi] >= MW);
        if (tx_afull && !drn) chk("afull_ready", 64'(in_ready), 64'd0);
        xf = in_valid & in_ready;
        ev = 1'b0;
        if (xf != '0) begin
            chk("xfer_onehot", 64'($onehot(xf)), 64'd1);
            p = 0;
            for (int q = N - 1; q >= 0; q--) if (xf[q]) p = q;
            if (srcw[p] == 0) begin
                int want;
                want = (ord.size() > 0) ? ord.pop_front() : -1;
                chk("rr_port", 64'(p), 64'(want));
                cap_ip[p] = in_dest_ip[32*p +: 32];
                cap_pt[p] = in_dest_port[16*p +: 16];
            end
            if (srcw[p] < MW) begin
                ev   = 1'b1;
                ed   = in_data[64*p +: 64];
                eeof = (srcw[p] == plen[p][srcp[p]] - 1) || (srcw[p] == MW - 1);
                eip  = cap_ip[p];
                ept  = cap_pt[p];
            end
            if (srcw[p] == plen[p][srcp[p]] - 1) begin
                srcp[p]++;
                srcw[p] = 0;
            end else begin
                srcw[p]++;
            end
        end
    endtask

    function automatic logic all_done();
        for (int p = 0; p < N; p++) if (srcp[p] < npk[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic rst_check(input logic now);
        if (!now) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_eof", 64'(tx_end_of_frame), 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_tx_ip", 64'(tx_dest_ip), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_ovf", 64'(overflow_seen), 64'd0);
        for (int p = 0; p < N; p++) begin
            chk("rst_pkt_count", 64'(pkt_count[CW*p +: CW]), 64'd0);
            chk("rst_trunc_count", 64'(trunc_count[CW*p +: CW]), 64'd0);
        end
        rst = 1'b0;
        in_valid = '0;
        in_eof = '0;
        tx_afull = 1'b0;
        tx_overflow = 1'b0;
        ev = 1'b0;
        cyc = 0;
        for (int p = 0; p < N; p++) begin
            srcp[p] = 0;
            srcw[p] = 0;
        end
    endtask

    task automatic run_round();
        int c;
        prep();
        for (c = 0; c < 3000; c++) begin
            step();
            if (all_done() && !ev) break;
        end
        if (c >= 3000) chk("round_timeout", 64'd1, 64'd0);
        for (int p = 0; p < N; p++) begin
            chk("pkt_count", 64'(pkt_count[CW*p +: CW]), 64'(npk[p]));
            chk("trunc_count", 64'(trunc_count[CW*p +: CW]), 64'(exp_trunc[p]));
        end
        chk("order_left", 64'(ord.size()), 64'd0);
    endtask

    task automatic setup(input int m0, input int m1, input int m2,
                         input int m3, input int l, input int am, input int g);
        npk[0] = m0; npk[1] = m1; npk[2] = m2; npk[3] = m3;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 8; k++) plen[p][k] = l;
        afmode = am;
        gaps = g;
        rnd++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_eof = '0;
        in_data = '0;
        in_dest_ip = '0;
        in_dest_port = '0;
        tx_afull = 1'b0;
        tx_overflow = 1'b0;
        ev = 1'b0;
        rnd = 0;
        rst_check(1'b1);

        setup(1, 0, 0, 0, 4, 0, 0);
        run_round();

        rst_check(1'b0);
        setup(2, 2, 0, 0, 3, 0, 0);
        run_round();

        rst_check(1'b0);
        setup(0, 1, 0, 0, 6, 2, 0);
        run_round();

        rst_check(1'b0);
        setup(0, 0, 2, 0, 8, 0, 0);
        plen[2][0] = 10;
        run_round();

        rst_check(1'b0);
        setup(3, 3, 3, 3, 1, 0, 0);
        run_round();

        @(negedge clk);
        tx_overflow = 1'b1;
        @(negedge clk);
        tx_overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("overflow_sticky", 64'(overflow_seen), 64'd1);
        end
        rst_check(1'b0);

        setup(2, 0, 0, 0, 2, 0, 0);
        plen[0][1] = 5;
        prep();
        for (int c = 0; c < 200; c++) begin
            step();
            if (srcp[0] == 1 && srcw[0] == 3) break;
        end
        chk("mid_pkt_pre_count", 64'(pkt_count[CW-1:0]), 64'd1);
        rst_check(1'b1);

        for (int r = 0; r < 8; r++) begin
            rst_check(1'b0);
            setup(0, 0, 0, 0, 1, 1, 1);
            for (int p = 0; p < N; p++) begin
                npk[p] = $urandom_range(0, 4);
                for (int k = 0; k < 8; k++) plen[p][k] = $urandom_range(1, 12);
            end
            run_round();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
